// File: rtl/adc_frame_pkg.sv
// Shared definitions for the ADC frame scheduler: FSM encoding, header layout and byte picker.
// ADC_FRAME_CSUM_EN adds the checksum trailer state.
package adc_frame_pkg;

`ifdef ADC_FRAME_CSUM_EN
    typedef enum logic [1:0] {StIdle, StHeader, StPayload, StTrailer} frame_state_e;
`else
    typedef enum logic [1:0] {StIdle, StHeader, StPayload} frame_state_e;
`endif

    localparam int unsigned HDR_BYTES     = 10;
    localparam logic [15:0] MAGIC_DEFAULT = 16'hADC0;

    // Offset of the high byte of each big-endian header field; the low byte follows.
    localparam logic [3:0] HDR_OFF_MAGIC = 4'd0;
    localparam logic [3:0] HDR_OFF_SEQ   = 4'd2;
    localparam logic [3:0] HDR_OFF_LEN   = 4'd4;
    localparam logic [3:0] HDR_OFF_N     = 4'd6;
    localparam logic [3:0] HDR_OFF_M     = 4'd8;

    function automatic logic [7:0] header_byte(input logic [3:0]  idx,
                                               input logic [15:0] magic,
                                               input logic [15:0] seq,
                                               input logic [15:0] len,
                                               input logic [15:0] n,
                                               input logic [15:0] m);
        case (idx)
            HDR_OFF_MAGIC:        return magic[15:8];
            HDR_OFF_MAGIC + 4'd1: return magic[7:0];
            HDR_OFF_SEQ:          return seq[15:8];
            HDR_OFF_SEQ + 4'd1:   return seq[7:0];
            HDR_OFF_LEN:          return len[15:8];
            HDR_OFF_LEN + 4'd1:   return len[7:0];
            HDR_OFF_N:            return n[15:8];
            HDR_OFF_N + 4'd1:     return n[7:0];
            HDR_OFF_M:            return m[15:8];
            HDR_OFF_M + 4'd1:     return m[7:0];
            default:              return 8'h00;
        endcase
    endfunction

endpackage

// File: rtl/adc_sample_fifo.sv
// Single-clock first-word-fall-through sample FIFO with occupancy count.
module adc_sample_fifo #(
    parameter int unsigned DEPTH = 512,
    parameter int unsigned WIDTH = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q;
    logic             do_push, do_pop;

    // Fullness is judged before any same-cycle pop, so a push into a full FIFO is dropped.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count_q == (AW + 1)'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/adc_frame_scheduler.sv
// Buffers ADC samples and emits header/payload frames on a byte AXI-Stream.
// Define ADC_FRAME_CSUM_EN to append a 16-bit payload sum trailer.
module adc_frame_scheduler
    import adc_frame_pkg::*;
#(
    parameter int unsigned FRAME_LEN      = 256,
    parameter int unsigned FIFO_DEPTH     = 512,
    parameter int unsigned TIMEOUT_CYCLES = 125000,
    parameter logic [15:0] MAGIC          = MAGIC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    input  logic        adc_valid,
    input  logic [15:0] adc_data,
    input  logic [15:0] n_valid,
    input  logic [15:0] m_active,
    output logic [7:0]  m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
    output logic [15:0] frame_seq,
    output logic        overflow,
    output logic [15:0] drop_count,
    output logic        busy
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW-1:0] FRAME_LEN_C = CW'(FRAME_LEN);

    logic [15:0]   fifo_rdata;
    logic [CW-1:0] fifo_count;
    logic          fifo_full, fifo_empty, fifo_pop;

    frame_state_e  state_q;
    logic [3:0]    hdr_idx_q;
    logic          lo_q;
    logic [CW-1:0] len_q, rem_q;
    logic [15:0]   n_q, m_q, seq_q, seq_cnt_q, frame_seq_q, drop_q;
    logic          overflow_q;
    logic [31:0]   tmo_q;
`ifdef ADC_FRAME_CSUM_EN
    logic [15:0]   csum_q;
`endif

    logic xfer, tmo_expired, start, last_sample;

    adc_sample_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (adc_valid),
        .wdata (adc_data),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign xfer        = m_axis_tvalid && m_axis_tready;
    assign tmo_expired = (TIMEOUT_CYCLES != 0) && (tmo_q == TIMEOUT_CYCLES);
    assign start       = (state_q == StIdle) && enable &&
                         ((fifo_count >= FRAME_LEN_C) || (!fifo_empty && tmo_expired));
    assign last_sample = (state_q == StPayload) && lo_q && (rem_q == CW'(1));
    assign fifo_pop    = xfer && (state_q == StPayload) && lo_q;

    // Stream outputs decode straight from state registers and the FIFO head, which only
    // moves on acceptance, so they hold steady under backpressure and clear on reset.
    assign m_axis_tvalid = (state_q != StIdle);
    assign busy          = (state_q != StIdle);
    assign frame_seq     = frame_seq_q;
    assign overflow      = overflow_q;
    assign drop_count    = drop_q;

    always_comb begin
        m_axis_tdata = 8'h00;
        m_axis_tlast = 1'b0;
        unique case (state_q)
            StHeader:  m_axis_tdata = header_byte(hdr_idx_q, MAGIC, seq_q, 16'(len_q), n_q, m_q);
            StPayload: begin
                m_axis_tdata = lo_q ? fifo_rdata[7:0] : fifo_rdata[15:8];
`ifndef ADC_FRAME_CSUM_EN
                m_axis_tlast = last_sample;
`endif
            end
`ifdef ADC_FRAME_CSUM_EN
            StTrailer: begin
                m_axis_tdata = lo_q ? csum_q[7:0] : csum_q[15:8];
                m_axis_tlast = lo_q;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            hdr_idx_q   <= '0;
            lo_q        <= 1'b0;
            len_q       <= '0;
            rem_q       <= '0;
            n_q         <= '0;
            m_q         <= '0;
            seq_q       <= '0;
            seq_cnt_q   <= '0;
            frame_seq_q <= '0;
`ifdef ADC_FRAME_CSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        state_q   <= StHeader;
                        hdr_idx_q <= '0;
                        lo_q      <= 1'b0;
                        len_q     <= (fifo_count >= FRAME_LEN_C) ? FRAME_LEN_C : fifo_count;
                        rem_q     <= (fifo_count >= FRAME_LEN_C) ? FRAME_LEN_C : fifo_count;
                        n_q       <= n_valid;
                        m_q       <= m_active;
                        seq_q     <= seq_cnt_q;
`ifdef ADC_FRAME_CSUM_EN
                        csum_q    <= '0;
`endif
                    end
                end
                StHeader: begin
                    if (xfer) begin
                        if (hdr_idx_q == 4'(HDR_BYTES - 1)) state_q <= StPayload;
                        else hdr_idx_q <= hdr_idx_q + 4'd1;
                    end
                end
                StPayload: begin
                    if (xfer) begin
                        lo_q <= !lo_q;
                        if (lo_q) begin
`ifdef ADC_FRAME_CSUM_EN
                            csum_q <= csum_q + fifo_rdata;
                            if (last_sample) state_q <= StTrailer;
                            else rem_q <= rem_q - 1'b1;
`else
                            if (last_sample) begin
                                state_q     <= StIdle;
                                seq_cnt_q   <= seq_cnt_q + 16'd1;
                                frame_seq_q <= seq_q;
                            end else begin
                                rem_q <= rem_q - 1'b1;
                            end
`endif
                        end
                    end
                end
`ifdef ADC_FRAME_CSUM_EN
                StTrailer: begin
                    if (xfer) begin
                        lo_q <= !lo_q;
                        if (lo_q) begin
                            state_q     <= StIdle;
                            seq_cnt_q   <= seq_cnt_q + 16'd1;
                            frame_seq_q <= seq_q;
                        end
                    end
                end
`endif
                default: state_q <= StIdle;
            endcase
        end
    end

    // Idle timer only runs while samples wait in IDLE; any new sample restarts it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q <= '0;
        end else if (adc_valid || fifo_empty || start) begin
            tmo_q <= '0;
        end else if ((state_q == StIdle) && (tmo_q != TIMEOUT_CYCLES)) begin
            tmo_q <= tmo_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow_q <= 1'b0;
            drop_q     <= '0;
        end else if (adc_valid && fifo_full) begin
            overflow_q <= 1'b1;
            if (drop_q != 16'hFFFF) drop_q <= drop_q + 16'd1;
        end
    end

endmodule

// File: tb/tb_adc_frame_scheduler.sv
// Directed bench for adc_frame_scheduler with FRAME_LEN=4, FIFO_DEPTH=8, TIMEOUT_CYCLES=20.
module tb_adc_frame_scheduler;
    localparam int unsigned FL = 4;
    localparam int unsigned FD = 8;
    localparam int unsigned TO = 20;

    logic        clk = 1'b0;
    logic        rst, enable, adc_valid, tvalid, tready, tlast, overflow, busy;
    logic [15:0] adc_data, n_valid, m_active, frame_seq, drop_count;
    logic [7:0]  tdata;

    always #4 clk = ~clk;

    adc_frame_scheduler #(
        .FRAME_LEN      (FL),
        .FIFO_DEPTH     (FD),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .adc_valid     (adc_valid),
        .adc_data      (adc_data),
        .n_valid       (n_valid),
        .m_active      (m_active),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .m_axis_tlast  (tlast),
        .frame_seq     (frame_seq),
        .overflow      (overflow),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    typedef struct {
        logic [15:0] s0, s1, s2, s3;
        logic [15:0] n, m;
        bit          toggle;
        logic [15:0] seq;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  exp_buf[$];
    logic [15:0] smp[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Expected byte stream for the samples in smp.
    task automatic build_exp(input logic [15:0] seq, input logic [15:0] n, input logic [15:0] m);
        logic [15:0] sum = 16'h0;
        logic [15:0] len = 16'(smp.size());
        exp_buf.delete();
        exp_buf.push_back(8'hAD); exp_buf.push_back(8'hC0);
        exp_buf.push_back(seq[15:8]); exp_buf.push_back(seq[7:0]);
        exp_buf.push_back(len[15:8]); exp_buf.push_back(len[7:0]);
        exp_buf.push_back(n[15:8]); exp_buf.push_back(n[7:0]);
        exp_buf.push_back(m[15:8]); exp_buf.push_back(m[7:0]);
        foreach (smp[i]) begin
            exp_buf.push_back(smp[i][15:8]);
            exp_buf.push_back(smp[i][7:0]);
            sum = sum + smp[i];
        end
`ifdef ADC_FRAME_CSUM_EN
        exp_buf.push_back(sum[15:8]);
        exp_buf.push_back(sum[7:0]);
`endif
    endtask

    task automatic push_samples();
        foreach (smp[i]) begin
            @(negedge clk);
            adc_valid = 1'b1;
            adc_data  = smp[i];
        end
        @(negedge clk);
        adc_valid = 1'b0;
    endtask

    // Collect one frame, checking bytes, tlast and stability under stalls.
    task automatic run_frame(input bit toggle, input int dis_at, input string name);
        int         idx   = 0;
        int         cyc   = 0;
        logic       stall = 1'b0;
        logic [7:0] pd    = 8'h0;
        logic       pl    = 1'b0;
        while (idx < exp_buf.size() && cyc < 400) begin
            @(posedge clk);
            #1;
            tready = toggle ? (cyc % 2 == 0) : 1'b1;
            if (idx == dis_at) enable = 1'b0;
            @(negedge clk);
            cyc++;
            if (stall) begin
                check($sformatf("%s hold tvalid", name), 32'(tvalid), 32'd1);
                check($sformatf("%s hold tdata", name), 32'(tdata), 32'(pd));
                check($sformatf("%s hold tlast", name), 32'(tlast), 32'(pl));
            end
            if (tvalid && tready) begin
                check($sformatf("%s byte%0d", name, idx), 32'(tdata), 32'(exp_buf[idx]));
                check($sformatf("%s tlast%0d", name, idx), 32'(tlast),
                      32'(idx == exp_buf.size() - 1));
                idx++;
            end
            stall = tvalid && !tready;
            pd    = tdata;
            pl    = tlast;
        end
        if (idx < exp_buf.size()) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d bytes, required %0d", name, idx, exp_buf.size());
        end
        @(posedge clk);
        #1;
        tready = 1'b0;
    endtask

    initial begin
        vec_t vecs[3];
        int   k;
        int   got;

        rst = 1'b1; enable = 1'b0; adc_valid = 1'b0; adc_data = '0;
        n_valid = '0; m_active = '0; tready = 1'b0;

        vecs[0] = '{16'h001, 16'h002, 16'h003, 16'h004, 16'h0005, 16'h0007, 1'b0, 16'd0};
        vecs[1] = '{16'h3FF, 16'h3FF, 16'h3FF, 16'h3FF, 16'h1234, 16'hABCD, 1'b1, 16'd1};
        vecs[2] = '{16'h155, 16'h2AA, 16'h000, 16'h3FF, 16'h0000, 16'hFFFF, 1'b1, 16'd2};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset tvalid", 32'(tvalid), 32'd0);
        check("reset tlast", 32'(tlast), 32'd0);
        check("reset tdata", 32'(tdata), 32'd0);
        check("reset busy", 32'(busy), 32'd0);
        check("reset overflow", 32'(overflow), 32'd0);
        check("reset drop_count", 32'(drop_count), 32'd0);
        check("reset frame_seq", 32'(frame_seq), 32'd0);
        enable = 1'b1;

        for (int i = 0; i < 3; i++) begin
            smp      = {vecs[i].s0, vecs[i].s1, vecs[i].s2, vecs[i].s3};
            n_valid  = vecs[i].n;
            m_active = vecs[i].m;
            build_exp(vecs[i].seq, vecs[i].n, vecs[i].m);
            push_samples();
            run_frame(vecs[i].toggle, -1, $sformatf("vec%0d", i));
            check($sformatf("vec%0d frame_seq", i), 32'(frame_seq), 32'(vecs[i].seq));
            check($sformatf("vec%0d busy", i), 32'(busy), 32'd0);
        end

        // Short frame forced by the idle timeout.
        smp = {16'h011, 16'h022};
        n_valid = 16'h0003; m_active = 16'h0004;
        build_exp(16'd3, 16'h0003, 16'h0004);
        push_samples();
        k = 0;
        do begin
            @(posedge clk);
            #1;
            k++;
        end while (!tvalid && k < 60);
        check("timeout latency", 32'(k), 32'(TO + 1));
        run_frame(1'b0, -1, "short");
        check("short frame_seq", 32'(frame_seq), 32'd3);

        // Stalled sink: 10 pushes into an 8-deep FIFO drop two.
        tready = 1'b0;
        n_valid = 16'h0A0B; m_active = 16'h0C0D;
        smp = {16'h101, 16'h102, 16'h103, 16'h104, 16'h105,
               16'h106, 16'h107, 16'h108, 16'h109, 16'h10A};
        push_samples();
        @(negedge clk);
        check("ovf overflow", 32'(overflow), 32'd1);
        check("ovf drop_count", 32'(drop_count), 32'd2);
        check("ovf stalled tvalid", 32'(tvalid), 32'd1);
        check("ovf stalled tdata", 32'(tdata), 32'hAD);

        // Drop enable mid-payload: frame completes, queued samples stay put.
        smp = {16'h101, 16'h102, 16'h103, 16'h104};
        build_exp(16'd4, 16'h0A0B, 16'h0C0D);
        run_frame(1'b0, 12, "enoff");
        check("enoff frame_seq", 32'(frame_seq), 32'd4);
        repeat (30) @(negedge clk);
        check("enoff idle tvalid", 32'(tvalid), 32'd0);
        check("enoff idle busy", 32'(busy), 32'd0);

        n_valid = 16'h1111; m_active = 16'h2222;
        smp = {16'h105, 16'h106, 16'h107, 16'h108};
        build_exp(16'd5, 16'h1111, 16'h2222);
        enable = 1'b1;
        run_frame(1'b1, -1, "resume");
        check("resume frame_seq", 32'(frame_seq), 32'd5);
        check("resume overflow sticky", 32'(overflow), 32'd1);
        check("resume drop_count", 32'(drop_count), 32'd2);

        // Reset in the middle of the payload.
        n_valid = 16'h0042; m_active = 16'h0043;
        smp = {16'h0AA, 16'h0BB, 16'h0CC, 16'h0DD};
        push_samples();
        got = 0;
        k   = 0;
        while (got < 12 && k < 100) begin
            @(negedge clk);
            tready = 1'b1;
            if (tvalid && tready) got++;
            k++;
        end
        check("rst partial bytes", 32'(got), 32'd12);
        rst = 1'b1;
        #1;
        check("rst tvalid", 32'(tvalid), 32'd0);
        check("rst busy", 32'(busy), 32'd0);
        check("rst frame_seq", 32'(frame_seq), 32'd0);
        check("rst overflow", 32'(overflow), 32'd0);
        check("rst drop_count", 32'(drop_count), 32'd0);
        @(negedge clk);
        rst    = 1'b0;
        tready = 1'b0;

        smp = {16'h0AA, 16'h0BB, 16'h0CC, 16'h0DD};
        build_exp(16'd0, 16'h0042, 16'h0043);
        push_samples();
        run_frame(1'b0, -1, "postrst");
        check("postrst frame_seq", 32'(frame_seq), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
